// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Remainder sits above the quotient in the packed result.
  function automatic int rem_lsb(input int w);
    return w;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract; the extra top bit of diff is the borrow that decides restore.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    if (diff[WIDTH+1]) begin
      rem_o = shifted[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider with busy/ready handshake.
// Divides magnitudes with a restoring loop, then applies truncating-division signs.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SIGNED_SUPPORT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W   = cnt_width(WIDTH);
  localparam int REM_LSB = rem_lsb(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;

  logic               op_signed;
  logic [WIDTH:0]     dvd_ext, dvs_ext;
  logic [WIDTH:0]     dvd_mag, dvs_mag;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes in WIDTH+1 bits so that |MIN| is representable.
  always_comb begin
    op_signed = (SIGNED_SUPPORT != 0) && is_signed;
    dvd_ext   = {op_signed & dividend[WIDTH-1], dividend};
    dvs_ext   = {op_signed & divisor[WIDTH-1], divisor};
    dvd_mag   = dvd_ext[WIDTH] ? -dvd_ext : dvd_ext;
    dvs_mag   = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    ready_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          neg_quo_d  = dvd_ext[WIDTH] ^ dvs_ext[WIDTH];
          neg_rem_d  = dvd_ext[WIDTH];
          ovf_pend_d = op_signed && (dividend == MIN_VAL) && (divisor == '1);
          quo_d      = dvd_mag[WIDTH-1:0];
          // Bit WIDTH of a magnitude is always 0: this seeds an empty partial remainder.
          rem_d      = {dvd_mag[WIDTH], {WIDTH{1'b0}}};
          dvs_d      = dvs_mag;
          if (divisor == '0) begin
            // Zero divisor bypasses the loop and reports on the next cycle.
            result_d                    = '0;
            result_d[REM_LSB +: WIDTH]  = dividend;
            result_d[WIDTH-1:0]         = '1;
            dbz_d                       = 1'b1;
            ovf_d                       = 1'b0;
            ready_d                     = 1'b1;
            state_d                     = S_DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_ITER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d                   = '0;
        result_d[REM_LSB +: WIDTH] = rem_fix;
        result_d[WIDTH-1:0]        = quo_fix;
        dbz_d                      = 1'b0;
        ovf_d                      = ovf_pend_q;
        ready_d                    = 1'b1;
        state_d                    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
    end
  end

  assign busy        = (state_q == S_ITER) || (state_q == S_FIX);
  assign ready       = ready_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: accepts are predicted from the handshake,
// expected results come from plain integer arithmetic, a monitor checks each ready.
module tb_seq_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           is_signed = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, ready;
  logic [2*W-1:0] result;
  logic           div_by_zero, overflow;

  logic           start32 = 1'b0;
  logic [31:0]    dvd32 = '0;
  logic [31:0]    dvs32 = '0;
  logic           busy32, ready32;
  logic [63:0]    result32;
  logic           dbz32, ovf32;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dbz;
    logic           ovf;
    int             acc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W), .SIGNED_SUPPORT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .ready(ready),
    .result(result), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  seq_divider #(.WIDTH(32), .SIGNED_SUPPORT(1)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(1'b0),
    .dividend(dvd32), .divisor(dvs32), .busy(busy32), .ready(ready32),
    .result(result32), .div_by_zero(dbz32), .overflow(ovf32)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: C-style truncating division on sign-extended integers.
  // lat = edges from the accept edge to the edge that raises ready.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int acc);
    exp_t e;
    int da, db, q, r;
    e.acc = acc;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 1;
    if (b == '0) begin
      e.res = {a, {W{1'b1}}};
      e.dbz = 1'b1;
      e.lat = 0;
    end else begin
      if (s) begin
        da    = int'($signed(a));
        db    = int'($signed(b));
        e.ovf = (a == 16'h8000) && (b == 16'hFFFF);
      end else begin
        da = int'(a);
        db = int'(b);
      end
      q     = da / db;
      r     = da % db;
      e.res = {r[W-1:0], q[W-1:0]};
    end
    return e;
  endfunction

  // Cycle counter: value equals the number of the most recent rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Predict accepts: inputs are stable at the falling edge before the accepting edge.
  initial forever begin
    @(negedge clk);
    if (!rst && start && !busy) sb.push_back(model(dividend, divisor, is_signed, cyc + 1));
  end

  // Compare every ready pulse against the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: ready=1 with no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("div_by_zero", div_by_zero, e.dbz);
        check("overflow", overflow, e.ovf);
        check("latency", cyc - e.acc, e.lat);
        check("busy_at_ready", busy, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("accept_timeout", busy, 1'b0);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           m, n, acc;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_result", result, '0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 8/7 with start held: three back-to-back operations
    @(posedge clk);
    #2;
    dividend = 16'd8; divisor = 16'd7; is_signed = 1'b0; start = 1'b1;
    repeat (52) @(posedge clk);
    #2;
    start = 1'b0;
    drain();

    // 51/5, operands changed and a stray start raised while busy
    do_op(16'd51, 16'd5, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    dividend = 16'h1234; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    drain();
    check("op_change_ignored", result, 32'h0001_000A);

    // -7/2 signed, then same bits unsigned
    do_op(16'hFFF9, 16'h0002, 1'b1);
    do_op(16'hFFF9, 16'h0002, 1'b0);
    drain();

    // divide by zero, held flags, then cleared by a valid op
    do_op(16'd100, 16'd0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("dbz_held", div_by_zero, 1'b1);
    check("dbz_result_held", result, 32'h0064_FFFF);
    do_op(16'd9, 16'd2, 1'b0);
    drain();
    check("dbz_cleared", div_by_zero, 1'b0);

    // signed MIN / -1, and the same bits unsigned
    do_op(16'h8000, 16'hFFFF, 1'b1);
    drain();
    check("ovf_held", overflow, 1'b1);
    do_op(16'h8000, 16'hFFFF, 1'b0);
    drain();

    // reset in the middle of iterating
    do_op(16'd1000, 16'd3, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", ready, 1'b0);
    check("abort_result", result, '0);
    check("abort_dbz", div_by_zero, 1'b0);
    check("abort_ovf", overflow, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    do_op(16'd500, 16'd7, 1'b0);
    drain();

    // 32-bit instance: FFFFFFFF/3
    @(posedge clk);
    #2;
    dvd32 = 32'hFFFF_FFFF; dvs32 = 32'd3; start32 = 1'b1;
    @(negedge clk);
    check("w32_idle_before", busy32, 1'b0);
    acc = cyc + 1;
    @(posedge clk);
    #2;
    start32 = 1'b0;
    n = 0;
    while (!ready32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w32_ready_seen", ready32, 1'b1);
    check("w32_latency", cyc - acc, 33);
    check("w32_result", result32, {32'h0, 32'h5555_5555});
    check("w32_flags", {dbz32, ovf32}, 2'b00);

    // randomized operations with corner-case bias
    for (int i = 0; i < 120; i++) begin
      m = $urandom_range(0, 9);
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      case (m)
        0: b = '0;
        1: begin a = 16'h8000; b = 16'hFFFF; s = 1'b1; end
        2: b = W'($urandom_range(1, 7));
        3: a = W'($urandom_range(0, 20));
        default: ;
      endcase
      do_op(a, b, s);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
